tstate_sequencer: RTL and testbench
===================================

Name: tstate_sequencer

Overview:
- Owns the instruction register (IR) and the 3-bit T-state counter that drive the combinational Decode block.
- Each clock it advances T, loads the IR during fetch, and stalls on slow memory.
- Recognises end-of-instruction and parks the CPU on a halt request.
- Sits between the memory bus and Decode. Decode's uinstr is fed back in, and a gated copy goes out to the datapath.

Parameters:
- MAX_T, 7: last legal T-state; instruction is forced to end after it.
- FETCH_T, 1: T-state whose clock edge latches bus_in into IR.
- MEM_BIT, 15: uinstr bit index meaning "this step accesses memory".

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- uinstr_in  in  16  microinstruction from Decode for current (instr_out, t_out)
- bus_in  in  16  memory/bus data
- mem_ready  in  1  memory completes access this cycle
- halt_req  in  1  level request to halt at next instruction boundary
- instr_out  out  16  IR contents, to Decode instr input
- t_out  out  3  current T-state, to Decode T input
- uinstr_out  out  16  uinstr_in, or 16'h0000 when halted
- halted  out  1  sequencer parked
- instr_end  out  1  one-cycle pulse on the edge that retires an instruction

Behaviour:
- Reset (async, reset_n=0): IR=0, T=0, state=RUN, halted=0, instr_end=0. All take effect immediately, including mid-stall or mid-instruction. On release, fetch begins at T0.
- States: RUN, STALL, HALT.
- Stall condition: uinstr_in[MEM_BIT]=1 and mem_ready=0.
- End condition: uinstr_in==16'h0000 (explicit end) or T==MAX_T.
- RUN, stall condition true: go to STALL. T and IR hold, and IR is not loaded even at FETCH_T.
- RUN, no stall:
  - If T==FETCH_T, IR <= bus_in.
  - If the end condition holds: T <= 0 and instr_end=1 next cycle. Then go to HALT if halt_req=1, else stay in RUN.
  - Otherwise T <= T+1. T never wraps to 0 except through the end condition.
- STALL: hold while mem_ready=0. When mem_ready=1, perform the RUN update for the held T on that edge (IR load, advance or end) and return to RUN.
- halt_req during STALL or mid-instruction is ignored until the boundary. Instructions are never abandoned.
- HALT: T=0, halted=1, uinstr_out=16'h0000. IR and T are frozen and mem_ready is ignored. When halt_req=0, return to RUN (halted=0 next cycle) and resume fetch at T0.
- uinstr_out passes uinstr_in combinationally in RUN/STALL and is zero in HALT.
- Latency: a new IR value is visible on instr_out the cycle after the FETCH_T edge.
- T arithmetic is 3-bit unsigned. MAX_T=7 means a T==7 step always ends.

Optional Feature:
- Macro: TSTATE_SEQ_SINGLE_STEP_EN.
- With the macro: extra input step (1 bit).
  - A step pulse while in HALT with halt_req=1 leaves HALT for exactly one instruction, then re-enters HALT at its boundary.
  - A pulse outside HALT is ignored.
  - halted=0 throughout the stepped instruction.
- Without the macro: no step port. HALT exits only when halt_req drops.

Decomposition:
- Shared package/header holds:
  - state encodings (RUN=0, STALL=1, HALT=2);
  - T width (3);
  - the uinstr field constant MEM_BIT, also used by the datapath;
  - the NOP microinstruction constant 16'h0000.
- One natural sub-module: tstate_counter (load-zero/increment/hold, 3-bit). The FSM and IR stay in the top.

Test Plan (bench stubs Decode: instr 0 gives T0=16'h0040, T1=16'h3480, T2=16'h8400, T3=16'h0000; MEM_BIT stimulus via a separate table entry):
1. Release reset with bus_in=16'h0300, mem_ready=1.
   - t_out runs 0,1,2,3 then 0.
   - instr_out=16'h0300 from the cycle after T1.
   - instr_end pulses once after the T3 edge.
2. Assert reset_n=0 mid-instruction at T=2.
   - t_out=0, instr_out=0, halted=0 immediately, without waiting for clk.
3. uinstr_in=16'h8400 (MEM_BIT set) at T2 with mem_ready=0 for 3 cycles.
   - t_out holds 2 for 3 cycles.
   - Advances to 3 on the edge where mem_ready=1.
4. Raise halt_req at T1.
   - Instruction completes.
   - halted=1, t_out=0, uinstr_out=16'h0000 after the end.
   - Lower halt_req: halted=0 next cycle, fetch restarts at T0.
5. Stub returns nonzero at all T.
   - t_out reaches 7, then instr_end pulses and T=0 (forced end at MAX_T).
6. With TSTATE_SEQ_SINGLE_STEP_EN, halted and halt_req=1, pulse step.
   - Exactly one instruction executes (one instr_end).
   - halted returns to 1 at its end.

Source files
------------

// File: rtl/tstate_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tstate_sequencer_pkg
// Shared definitions for the T-state sequencer and the blocks around it.
//   - seq_state_e : sequencer FSM encodings (RUN=0, STALL=1, HALT=2)
//   - T_W         : width of the T-state counter
//   - UI_MEM_BIT  : uinstr bit meaning "this step accesses memory"
//                   (also used by the datapath)
//   - UINSTR_NOP  : all-zero microinstruction, marks an explicit end
// -----------------------------------------------------------------------------
package tstate_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    localparam int          T_W        = 3;
    localparam int          UI_MEM_BIT = 15;
    localparam logic [15:0] UINSTR_NOP = 16'h0000;

endpackage

// File: rtl/tstate_sequencer_counter.sv
// -----------------------------------------------------------------------------
// tstate_counter
// T-state counter: clear-to-zero, increment or hold, T_W bits wide.
// Clear has priority over increment.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (counter -> 0)
//   clr_i    in   load zero on this edge
//   inc_i    in   increment on this edge
//   t_o      out  current T-state
// -----------------------------------------------------------------------------
module tstate_counter
    import tstate_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clr_i,
    input  logic           inc_i,
    output logic [T_W-1:0] t_o
);

    logic [T_W-1:0] t_q;
    logic [T_W-1:0] t_d;

    always_comb begin
        t_d = t_q;
        if (clr_i) begin
            t_d = '0;
        end else if (inc_i) begin
            t_d = t_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/tstate_sequencer.sv
// -----------------------------------------------------------------------------
// tstate_sequencer
// Owns the instruction register and the T-state counter feeding Decode.
// Advances T each clock, loads IR at FETCH_T, stalls on slow memory, retires
// instructions (explicit NOP or T==MAX_T) and parks in HALT on halt_req at an
// instruction boundary.
//
// Optional macro TSTATE_SEQ_SINGLE_STEP_EN adds input 'step': a pulse while
// halted with halt_req=1 runs exactly one instruction, then re-parks.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   uinstr_in   in   16  microinstruction from Decode for (instr_out, t_out)
//   bus_in      in   16  memory/bus data
//   mem_ready   in   memory completes access this cycle
//   halt_req    in   level request to halt at next instruction boundary
//   step        in   single-step pulse (only with TSTATE_SEQ_SINGLE_STEP_EN)
//   instr_out   out  16  IR contents
//   t_out       out  3   current T-state
//   uinstr_out  out  16  uinstr_in, or NOP while halted
//   halted      out  sequencer parked
//   instr_end   out  one-cycle pulse after the edge that retires an instruction
// -----------------------------------------------------------------------------
module tstate_sequencer
    import tstate_sequencer_pkg::*;
#(
    parameter int MAX_T   = 7,
    parameter int FETCH_T = 1,
    parameter int MEM_BIT = UI_MEM_BIT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [15:0]    uinstr_in,
    input  logic [15:0]    bus_in,
    input  logic           mem_ready,
    input  logic           halt_req,
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
    input  logic           step,
`endif
    output logic [15:0]    instr_out,
    output logic [T_W-1:0] t_out,
    output logic [15:0]    uinstr_out,
    output logic           halted,
    output logic           instr_end
);

    localparam logic [T_W-1:0] MAX_T_L   = T_W'(MAX_T);
    localparam logic [T_W-1:0] FETCH_T_L = T_W'(FETCH_T);

    seq_state_e     state_q;
    logic [15:0]    ir_q;
    logic           halted_q;
    logic           instr_end_q;
    logic [T_W-1:0] t_q;

    logic stall_cond;
    logic end_cond;
    logic advance;
    logic retire;
    logic park;

    // A memory step without ready holds everything, including the IR load.
    assign stall_cond = uinstr_in[MEM_BIT] && !mem_ready;
    assign end_cond   = (uinstr_in == UINSTR_NOP) || (t_q == MAX_T_L);

    // 'advance' is the single "perform the RUN update this edge" strobe; a
    // STALL exit is the same update for the held T once memory is ready.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            ST_RUN:   advance = !stall_cond;
            ST_STALL: advance = mem_ready;
            default:  advance = 1'b0;
        endcase
    end

    assign retire = advance && end_cond;

`ifdef TSTATE_SEQ_SINGLE_STEP_EN
    logic step_active_q;
    // A stepped instruction always re-parks at its boundary.
    assign park = halt_req || step_active_q;
`else
    assign park = halt_req;
`endif

    tstate_counter u_tcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (retire),
        .inc_i   (advance && !end_cond),
        .t_o     (t_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            ir_q        <= '0;
            halted_q    <= 1'b0;
            instr_end_q <= 1'b0;
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
            step_active_q <= 1'b0;
`endif
        end else begin
            instr_end_q <= retire;
            if (advance && (t_q == FETCH_T_L)) begin
                ir_q <= bus_in;
            end
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (retire) begin
                        state_q  <= park ? ST_HALT : ST_RUN;
                        halted_q <= park;
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
                        step_active_q <= 1'b0;
`endif
                    end else if (advance) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_STALL;
                    end
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
                    end else if (step) begin
                        state_q       <= ST_RUN;
                        halted_q      <= 1'b0;
                        step_active_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_out  = ir_q;
    assign t_out      = t_q;
    assign uinstr_out = (state_q == ST_HALT) ? UINSTR_NOP : uinstr_in;
    assign halted     = halted_q;
    assign instr_end  = instr_end_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tstate_sequencer
// Directed bench for tstate_sequencer with a stubbed Decode block.
// Decode stub (mode 0): T0=0040, T1=3480, T2=8400 (memory step), T3=0000.
// Decode stub (mode 1): 0040 at every T, so the instruction ends at MAX_T.
// -----------------------------------------------------------------------------
module tb_tstate_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] uinstr_in;
    logic [15:0] bus_in;
    logic        mem_ready;
    logic        halt_req;
    logic [15:0] instr_out;
    logic [2:0]  t_out;
    logic [15:0] uinstr_out;
    logic        halted;
    logic        instr_end;
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    int mode;
    int n_vec;
    int n_mis;

    tstate_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uinstr_in  (uinstr_in),
        .bus_in     (bus_in),
        .mem_ready  (mem_ready),
        .halt_req   (halt_req),
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .instr_out  (instr_out),
        .t_out      (t_out),
        .uinstr_out (uinstr_out),
        .halted     (halted),
        .instr_end  (instr_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode stub; instruction contents do not matter for these sequences.
    always_comb begin
        uinstr_in = 16'h0040;
        if (mode == 0) begin
            case (t_out)
                3'd0:    uinstr_in = 16'h0040;
                3'd1:    uinstr_in = 16'h3480;
                3'd2:    uinstr_in = 16'h8400;
                default: uinstr_in = 16'h0000;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Test 1 expectations, one entry per negedge after reset release.
    logic [2:0]  t1_t   [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    logic [15:0] t1_ir  [5] = '{16'h0000, 16'h0300, 16'h0300, 16'h0300, 16'h0300};
    logic        t1_end [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        n_vec     = 0;
        n_mis     = 0;
        mode      = 0;
        reset_n   = 1'b0;
        bus_in    = 16'h0300;
        mem_ready = 1'b1;
        halt_req  = 1'b0;
`ifdef TSTATE_SEQ_SINGLE_STEP_EN
        step      = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_t",      32'(t_out), 32'd0);
        check("rst_ir",     32'(instr_out), 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_end",    32'(instr_end), 32'd0);
        check("rst_uout",   32'(uinstr_out), 32'h0040);

        // 1: basic fetch/execute of a 4-step instruction
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t1_t[%0d]", i),   32'(t_out), 32'(t1_t[i]));
            check($sformatf("t1_ir[%0d]", i),  32'(instr_out), 32'(t1_ir[i]));
            check($sformatf("t1_end[%0d]", i), 32'(instr_end), 32'(t1_end[i]));
        end

        // 2: asynchronous reset mid-instruction at T2
        @(negedge clk);
        check("t2_pre_t", 32'(t_out), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("t2_async_t",      32'(t_out), 32'd0);
        check("t2_async_ir",     32'(instr_out), 32'h0);
        check("t2_async_halted", 32'(halted), 32'd0);

        // 3: memory stall at T2 for three cycles
        @(negedge clk);
        reset_n   = 1'b1;
        bus_in    = 16'h1234;
        mem_ready = 1'b0;
        @(negedge clk);
        check("t3_t1", 32'(t_out), 32'd1);
        @(negedge clk);
        check("t3_t2",  32'(t_out), 32'd2);
        check("t3_ir",  32'(instr_out), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3_hold[%0d]", i), 32'(t_out), 32'd2);
            check($sformatf("t3_uout[%0d]", i), 32'(uinstr_out), 32'h8400);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("t3_adv_t", 32'(t_out), 32'd3);
        @(negedge clk);
        check("t3_end_t",   32'(t_out), 32'd0);
        check("t3_end_end", 32'(instr_end), 32'd1);

        // 4: halt request raised at T1 takes effect at the boundary
        @(negedge clk);
        check("t4_t1", 32'(t_out), 32'd1);
        halt_req = 1'b1;
        @(negedge clk);
        check("t4_mid_halted_a", 32'(halted), 32'd0);
        @(negedge clk);
        check("t4_mid_halted_b", 32'(halted), 32'd0);
        check("t4_mid_t",        32'(t_out), 32'd3);
        @(negedge clk);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_end",    32'(instr_end), 32'd1);
        check("t4_t",      32'(t_out), 32'd0);
        check("t4_uout",   32'(uinstr_out), 32'h0000);
        mem_ready = 1'b0;
        @(negedge clk);
        check("t4_park_halted", 32'(halted), 32'd1);
        check("t4_park_t",      32'(t_out), 32'd0);
        check("t4_park_end",    32'(instr_end), 32'd0);
        mem_ready = 1'b1;
        halt_req  = 1'b0;
        @(negedge clk);
        check("t4_resume_halted", 32'(halted), 32'd0);
        check("t4_resume_t",      32'(t_out), 32'd0);
        check("t4_resume_uout",   32'(uinstr_out), 32'h0040);
        @(negedge clk);
        check("t4_resume_t1", 32'(t_out), 32'd1);

        // 5: forced end at MAX_T when Decode never returns NOP
        reset_n = 1'b0;
        @(negedge clk);
        mode    = 1;
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("t5_t[%0d]", i),   32'(t_out), 32'(i % 8));
            check($sformatf("t5_end[%0d]", i), 32'(instr_end), (i == 8) ? 32'd1 : 32'd0);
        end

`ifdef TSTATE_SEQ_SINGLE_STEP_EN
        // 6: single-step one instruction out of HALT
        begin
            int pulses;
            reset_n = 1'b0;
            @(negedge clk);
            mode     = 0;
            halt_req = 1'b1;
            reset_n  = 1'b1;
            repeat (4) @(negedge clk);
            check("t6_parked", 32'(halted), 32'd1);
            @(negedge clk);
            check("t6_still_parked", 32'(halted), 32'd1);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            check("t6_stepping_halted", 32'(halted), 32'd0);
            check("t6_stepping_t",      32'(t_out), 32'd0);
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (instr_end) pulses++;
            end
            check("t6_pulses",     32'(pulses), 32'd1);
            check("t6_reparked",   32'(halted), 32'd1);
            check("t6_reparked_t", 32'(t_out), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
